// File: rtl/mdu_hilo.sv
// Multiply/divide unit with architectural HI/LO registers.
// Launches mult/multu/div/divu and computes the result at launch time.
// The result is held in a pending register and committed after a fixed busy window.
// mthi/mtlo write directly. A taken exception (req) discards anything launched that cycle.
module mdu_hilo #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic        req,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, stateNext;
  logic [31:0]        cnt;
  logic [31:0]        pendHi, pendLo;
  logic               pendValid;
  logic               isMul, isDiv, divZero;
  logic               launch, wrHi, wrLo, commit;
  logic signed [63:0] prodS;
  logic [63:0]        prodU;
  logic [31:0]        dvsS, dvsU, quoS, remS, quoU, remU;
  logic [31:0]        resHi, resLo;

  // Operation decode and full-width arithmetic on the launch operands
  always_comb begin
    isMul   = (md_op == 3'd1) || (md_op == 3'd2);
    isDiv   = (md_op == 3'd3) || (md_op == 3'd4);
    divZero = isDiv && (rt == '0);
    prodS   = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
    prodU   = {32'd0, rs} * {32'd0, rt};
    // A zero divisor and the one overflowing signed case (INT_MIN / -1) both divide by 1.
    // For INT_MIN / -1 this yields quotient INT_MIN and remainder 0, which is the wanted result.
    dvsS    = ((rt == '0) || (rs == 32'h8000_0000 && rt == '1)) ? 32'd1 : rt;
    dvsU    = (rt == '0) ? 32'd1 : rt;
    quoS    = $signed(rs) / $signed(dvsS);
    remS    = $signed(rs) % $signed(dvsS);
    quoU    = rs / dvsU;
    remU    = rs % dvsU;
    resHi   = '0;
    resLo   = '0;
    case (md_op)
      3'd1:    begin resHi = prodS[63:32]; resLo = prodS[31:0]; end
      3'd2:    begin resHi = prodU[63:32]; resLo = prodU[31:0]; end
      3'd3:    begin resHi = remS;         resLo = quoS;        end
      3'd4:    begin resHi = remU;         resLo = quoU;        end
      default: begin resHi = '0;           resLo = '0;          end
    endcase
  end

  // Next-state and per-cycle control strobes
  always_comb begin
    stateNext = state;
    launch    = 1'b0;
    wrHi      = 1'b0;
    wrLo      = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (!req) begin
          if (start && (isMul || isDiv)) begin
            launch    = 1'b1;
            stateNext = RUN;
          end
          wrHi = (md_op == 3'd5);
          wrLo = (md_op == 3'd6);
        end
      end
      RUN: begin
        if (cnt <= 32'd1) begin
          commit    = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  // Busy flag, cycle counter, pending result and HI/LO registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      busy      <= 1'b0;
      cnt       <= '0;
      pendHi    <= '0;
      pendLo    <= '0;
      pendValid <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      busy <= (stateNext == RUN);
      if (launch) begin
        pendHi    <= resHi;
        pendLo    <= resLo;
        pendValid <= !divZero;
        cnt       <= isMul ? MULT_CYCLES : DIV_CYCLES;
      end else if (state == RUN) begin
        cnt <= cnt - 32'd1;
      end
      if (commit && pendValid) begin
        hi <= pendHi;
        lo <= pendLo;
      end
      if (wrHi) hi <= rs;
      if (wrLo) lo <= rs;
    end
  end

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo.
// A behavioural model of HI/LO/busy is checked against the DUT on every falling edge.
// Directed literal checks pin the model's expectations.
module tb_mdu_hilo;

  localparam int unsigned MULT_N = 5;
  localparam int unsigned DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset, start, req;
  logic [2:0]  md_op;
  logic [31:0] rs, rt;
  logic        busy;
  logic [31:0] hi, lo;

  int vectors     = 0;
  int miscompares = 0;
  bit checkEn     = 0;

  // Model state
  logic [31:0] mHi = '0, mLo = '0, pHi = '0, pLo = '0;
  int          mLeft   = 0;
  bit          mCommit = 0;

  mdu_hilo #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .rs(rs), .rt(rt), .req(req), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference arithmetic from the architectural definitions
  function automatic void refResult(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] rh, output logic [31:0] rl, output bit ok);
    int              sa, sb;
    longint          sp, q, r;
    longint unsigned up;
    sa = a; sb = b;
    ok = 1; rh = '0; rl = '0;
    case (op)
      3'd1: begin sp = longint'(sa) * longint'(sb); rh = sp[63:32]; rl = sp[31:0]; end
      3'd2: begin up = 64'(a) * 64'(b); rh = up[63:32]; rl = up[31:0]; end
      3'd3: begin
        if (b == 0) ok = 0;
        else begin q = longint'(sa) / longint'(sb); r = longint'(sa) % longint'(sb); rl = q[31:0]; rh = r[31:0]; end
      end
      3'd4: begin
        if (b == 0) ok = 0;
        else begin rl = a / b; rh = a % b; end
      end
      default: ok = 0;
    endcase
  endfunction

  // Behavioural model: countdown of remaining busy cycles, commit when it expires
  always @(posedge clk) begin
    if (!reset) begin
      mHi = '0; mLo = '0; mLeft = 0; mCommit = 0;
    end else if (mLeft > 0) begin
      if (start || (md_op >= 3'd1 && md_op <= 3'd6)) begin
        $display("FAIL protocol: op issued while busy, got start=%0b md_op=%0d required idle inputs", start, md_op);
        miscompares++;
      end
      mLeft--;
      if (mLeft == 0 && mCommit) begin mHi = pHi; mLo = pLo; end
    end else if (!req) begin
      if (start && md_op >= 3'd1 && md_op <= 3'd4) begin
        refResult(md_op, rs, rt, pHi, pLo, mCommit);
        mLeft = (md_op <= 3'd2) ? MULT_N : DIV_N;
      end
      if (md_op == 3'd5) mHi = rs;
      if (md_op == 3'd6) mLo = rs;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (checkEn) begin
      vectors++;
      if (busy !== (mLeft > 0) || hi !== mHi || lo !== mLo) begin
        miscompares++;
        $display("FAIL cycle @%0t: busy/hi/lo got %0b/%h/%h required %0b/%h/%h",
                 $time, busy, hi, lo, (mLeft > 0), mHi, mLo);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 9));
      default: return $urandom;
    endcase
  endfunction

  // Launch one operation and count the busy cycles that follow (bounded)
  task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int cyc);
    start = 1'b1; md_op = op; rs = a; rt = b; req = 1'b0;
    tick();
    start = 1'b0; md_op = 3'd0; rs = $urandom; rt = $urandom;
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      tick();
    end
  endtask

  // One protocol-legal random cycle
  task automatic randCycle(input bit allowReset);
    reset = !(allowReset && $urandom_range(0, 49) == 0);
    req   = ($urandom_range(0, 9) == 0);
    rs    = pick();
    rt    = pick();
    if (mLeft > 0) begin
      start = 1'b0;
      md_op = $urandom_range(0, 1) ? 3'd0 : 3'd7;
    end else begin
      start = ($urandom_range(0, 3) != 0);
      md_op = 3'($urandom_range(0, 7));
    end
    tick();
  endtask

  initial begin
    int cyc;
    reset = 1'b0; start = 1'b0; req = 1'b0; md_op = 3'd0; rs = '0; rt = '0;
    tick();
    checkEn = 1;
    tick();
    reset = 1'b1;
    repeat (20) randCycle(0);

    // Reset after random activity
    reset = 1'b0; start = 1'b0; md_op = 3'd0; req = 1'b0;
    tick();
    chk("reset hi", hi, 32'h0);
    chk("reset lo", lo, 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    tick();
    reset = 1'b1;

    runOp(3'd1, 32'hFFFF_FFFF, 32'h0000_0002, cyc);
    chk("mult busy cycles", cyc, 32'd5);
    chk("mult hi", hi, 32'hFFFF_FFFF);
    chk("mult lo", lo, 32'hFFFF_FFFE);

    runOp(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, cyc);
    chk("multu busy cycles", cyc, 32'd5);
    chk("multu hi", hi, 32'h0000_0001);
    chk("multu lo", lo, 32'hFFFF_FFFE);

    runOp(3'd3, 32'hFFFF_FFF9, 32'h0000_0002, cyc);
    chk("div busy cycles", cyc, 32'd10);
    chk("div lo", lo, 32'hFFFF_FFFD);
    chk("div hi", hi, 32'hFFFF_FFFF);

    md_op = 3'd5; rs = 32'h0000_1234; tick();
    chk("mthi hi", hi, 32'h0000_1234);
    md_op = 3'd6; rs = 32'h0000_5678; tick();
    chk("mtlo lo", lo, 32'h0000_5678);
    chk("mtlo keeps hi", hi, 32'h0000_1234);
    md_op = 3'd0;

    runOp(3'd4, 32'h0000_0007, 32'h0000_0000, cyc);
    chk("divu/0 busy cycles", cyc, 32'd10);
    chk("divu/0 hi", hi, 32'h0000_1234);
    chk("divu/0 lo", lo, 32'h0000_5678);

    runOp(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    chk("div ovf lo", lo, 32'h8000_0000);
    chk("div ovf hi", hi, 32'h0000_0000);

    // Launch under an exception is discarded
    start = 1'b1; md_op = 3'd1; rs = 32'd3; rt = 32'd4; req = 1'b1;
    tick();
    start = 1'b0; md_op = 3'd0; req = 1'b0;
    chk("req mult busy", 32'(busy), 32'h0);
    tick();
    chk("req mult hi", hi, 32'h0000_0000);
    chk("req mult lo", lo, 32'h8000_0000);

    md_op = 3'd5; rs = 32'hDEAD_BEEF; req = 1'b1; tick();
    md_op = 3'd0; req = 1'b0;
    chk("req mthi hi", hi, 32'h0000_0000);

    // Exception during an in-flight div does not cancel it
    start = 1'b1; md_op = 3'd3; rs = 32'd100; rt = 32'd7;
    tick();
    start = 1'b0; md_op = 3'd0;
    chk("div inflight busy", 32'(busy), 32'h1);
    req = 1'b1; tick(); tick(); req = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin cyc++; tick(); end
    chk("div under req lo", lo, 32'd14);
    chk("div under req hi", hi, 32'd2);

    // Reset on the third busy cycle of a mult: no late commit
    start = 1'b1; md_op = 3'd1; rs = 32'd3; rt = 32'd4;
    tick();
    start = 1'b0; md_op = 3'd0;
    tick(); tick();
    reset = 1'b0; tick();
    chk("abort busy", 32'(busy), 32'h0);
    chk("abort hi", hi, 32'h0);
    chk("abort lo", lo, 32'h0);
    reset = 1'b1;
    repeat (8) tick();
    chk("no late commit hi", hi, 32'h0);
    chk("no late commit lo", lo, 32'h0);

    repeat (2000) randCycle(1);

    reset = 1'b1; start = 1'b0; md_op = 3'd0; req = 1'b0;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mdu_hilo.md
# mdu_hilo

Multiply/divide unit with HI/LO registers, located in the EX stage of the P7 pipeline beside the ALU. It accepts mult/multu/div/divu/mthi/mtlo from the EX-stage instruction and produces the `busy` flag that the hazard/forwarding unit combines with `start` and `isdm` to stall the decode stage. It also supplies HI/LO to the EX result mux for mfhi/mflo. Interrupt/exception requests suppress new operations, so cancelled instructions cannot modify architectural HI/LO.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low (0 = reset on the clock edge)
- start  input  1  one-cycle launch strobe for md_op 1..4
- md_op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (no-op)
- rs  input  32  forwarded rs value (dividend / multiplicand / mthi-mtlo source)
- rt  input  32  forwarded rt value (divisor / multiplier)
- req  input  1  exception/interrupt taken this cycle; blocks all writes launched this cycle
- busy  output  1  operation in flight
- hi  output  32  HI register
- lo  output  32  LO register

## Operation
- States: IDLE, RUN. Reset: state IDLE, busy=0, hi=0, lo=0, counter=0, pending result=0.
- IDLE, start=1, req=0, md_op∈{1..4}: latch the result into internal pend_hi/pend_lo. Load counter with MULT_CYCLES or DIV_CYCLES and go to RUN. hi/lo are unchanged.
- Arithmetic:
  - mult: signed 32×32→64, hi=[63:32], lo=[31:0].
  - multu: unsigned 32×32→64, same HI/LO split as mult.
  - div: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - divu: unsigned quotient/remainder.
  - div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Divide by zero (rt=0, div/divu): the unit goes busy for the full DIV_CYCLES, and hi/lo keep their old values at completion.
- RUN: counter decrements each cycle. On the edge where the counter goes 1→0, commit hi/lo from the pending result (unless divide-by-zero) and return to IDLE.
- mthi/mtlo (md_op 5/6, start ignored) in IDLE with req=0: write rs to hi or lo on the next edge. No busy, and the other register is unchanged.
- req=1: the launch or mthi/mtlo in that cycle is discarded. An operation already in RUN is not cancelled and completes normally.
- start, or md_op 1..6, while in RUN: ignored. The stall unit guarantees this never happens; the bench flags it as a protocol error.
- start=1 with md_op ∈ {0,5,6,7}: no launch; md_op 5/6 still act as mthi/mtlo.
- reset=0 mid-operation: abort, return to the reset values on that edge, and discard the pending result.

## Timing
- Launch at edge E0 (start sampled high). busy=1 from E0 through E(N−1), which is N cycles, with N=MULT_CYCLES or DIV_CYCLES.
- hi/lo updated at edge EN, and busy=0 in the same cycle that hi/lo show the new value. An mfhi issued after the stall therefore reads the result with no extra bubble.
- A back-to-back launch is allowed in the first cycle busy=0.
- mthi/mtlo: hi/lo updated at the edge after the request, with 1-cycle visibility latency.
- busy and hi/lo are registered only. No combinational path from any input to any output.
- For interlock purposes the stall unit treats the launch cycle as `start`; busy covers the cycles that follow.

## Test plan
- Reset: hold reset=0 for 2 edges after random activity. Required: hi=lo=0 and busy=0 on the first reset edge.
- mult rs=0xFFFFFFFF, rt=0x00000002. Required: busy for exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- multu with the same operands. Required: hi=0x00000001, lo=0xFFFFFFFE.
- div rs=0xFFFFFFF9 (−7), rt=2. Required: busy for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu 7/0 after mthi 0x1234 and mtlo 0x5678. Required: busy for 10 cycles, then hi=0x1234, lo=0x5678 unchanged.
- Exceptions and reset:
  - mult launched with req=1: no busy, hi/lo unchanged.
  - req=1 during an in-flight div: the div still commits.
  - reset=0 at cycle 3 of a mult: busy=0, hi=lo=0, and no late commit.
